// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the conv1d_requant slice.
//   ACC_W / LANES : default accumulator width and int8 lanes per output word
//   Q31_*         : fixed-point constants used by the SRDHM stage
//   cfg_t         : latched requantization configuration
//   CFG_DEFAULT   : reset configuration (mult 0.5, shift +1 -> identity)
//   left_amt / right_amt : split the signed shift into its two halves
package conv_pkg;

  localparam int ACC_W = 32;
  localparam int LANES = 4;

  localparam logic [31:0] Q31_MIN  = 32'h8000_0000;
  localparam logic [31:0] Q31_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] Q31_HALF = 32'h4000_0000;

  // Rounding nudges for the 64-bit product: +2^30 or 1-2^30.
  localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

  typedef struct packed {
    logic [31:0] mult;
    logic [5:0]  shift;
    logic [8:0]  out_offset;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    mult:       Q31_HALF,
    shift:      6'd1,
    out_offset: 9'd0,
    act_min:    8'h80,
    act_max:    8'h7F
  };

  // Left shift applied to the accumulator: max(shift, 0).
  function automatic logic [4:0] left_amt(input logic [5:0] shift);
    return shift[5] ? 5'd0 : shift[4:0];
  endfunction

  // Rounding right shift applied after SRDHM: max(-shift, 0).
  function automatic logic [4:0] right_amt(input logic [5:0] shift);
    logic [5:0] neg;
    neg = 6'd0 - shift;
    return shift[5] ? neg[4:0] : 5'd0;
  endfunction

endpackage

// File: rtl/requant_mul.sv
// requant_mul: stages S2 and S3 of the requantizer.
//   S2: y = saturating rounding doubling high multiply of x by mult
//   S3: rounding arithmetic right shift, add output zero-point, clamp to int8
// Ports:
//   clk, reset            clock / synchronous active-high reset
//   adv                   pipeline advance; all stages move together
//   s1_valid/last/x       element leaving S1
//   mult, rshift          Q31 multiplier and right shift amount (0..31)
//   out_offset            signed 9-bit zero-point
//   act_min, act_max      signed int8 clamp bounds
//   s2_valid              S2 occupancy (for busy)
//   s3_valid/last/byte    element ready for the packer
module requant_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  input  logic        s1_valid,
  input  logic        s1_last,
  input  logic [31:0] s1_x,
  input  logic [31:0] mult,
  input  logic [4:0]  rshift,
  input  logic [8:0]  out_offset,
  input  logic [7:0]  act_min,
  input  logic [7:0]  act_max,
  output logic        s2_valid,
  output logic        s3_valid,
  output logic        s3_last,
  output logic [7:0]  s3_byte
);
  import conv_pkg::*;

  // ---------------- S2: SRDHM ----------------
  logic signed [63:0] x64;
  logic signed [63:0] m64;
  logic signed [63:0] prod;
  logic signed [63:0] prod_nudged;
  logic [31:0]        quot;
  logic [31:0]        y_next;

  always_comb begin
    x64         = signed'({{32{s1_x[31]}}, s1_x});
    m64         = signed'({{32{mult[31]}}, mult});
    prod        = x64 * m64;
    prod_nudged = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
    // Arithmetic shift floors; bump negatives with a remainder to truncate toward zero.
    quot        = prod_nudged[62:31];
    if (prod_nudged[63] && (|prod_nudged[30:0]))
      quot = quot + 32'd1;
    y_next = ((s1_x == Q31_MIN) && (mult == Q31_MIN)) ? Q31_MAX : quot;
  end

  logic        s2_valid_reg;
  logic        s2_last_reg;
  logic [31:0] s2_y_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_y_reg     <= '0;
    end else if (adv) begin
      s2_valid_reg <= s1_valid;
      s2_last_reg  <= s1_last;
      s2_y_reg     <= y_next;
    end
  end

  // ---------------- S3: rounding shift + offset + clamp ----------------
  logic [31:0]        mask;
  logic [31:0]        thr;
  logic [31:0]        rem;
  logic signed [31:0] z;
  logic               round_up;
  logic [33:0]        sum;
  logic [7:0]         byte_next;

  always_comb begin
    mask     = (32'd1 << rshift) - 32'd1;
    // Ties round away from zero: negatives need a strictly larger remainder.
    thr      = {1'b0, mask[31:1]} + {31'd0, s2_y_reg[31]};
    rem      = s2_y_reg & mask;
    z        = $signed(s2_y_reg) >>> rshift;
    round_up = rem > thr;
    sum      = {{2{z[31]}}, z} + {33'd0, round_up} + {{25{out_offset[8]}}, out_offset};
    if ($signed(sum) < $signed({{26{act_min[7]}}, act_min}))
      byte_next = act_min;
    else if ($signed(sum) > $signed({{26{act_max[7]}}, act_max}))
      byte_next = act_max;
    else
      byte_next = sum[7:0];
  end

  logic       s3_valid_reg;
  logic       s3_last_reg;
  logic [7:0] s3_byte_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid_reg <= 1'b0;
      s3_last_reg  <= 1'b0;
      s3_byte_reg  <= '0;
    end else if (adv) begin
      s3_valid_reg <= s2_valid_reg;
      s3_last_reg  <= s2_last_reg;
      s3_byte_reg  <= byte_next;
    end
  end

  assign s2_valid = s2_valid_reg;
  assign s3_valid = s3_valid_reg;
  assign s3_last  = s3_last_reg;
  assign s3_byte  = s3_byte_reg;

endmodule

// File: rtl/conv1d_requant.sv
// conv1d_requant: requantizes a stream of signed convolution accumulators to
// int8 and packs LANES results per 32-bit output word (lane 0 in the MSBs).
// Ports:
//   clk, reset                      clock / synchronous active-high reset
//   cfg_we + cfg_*                  configuration, accepted only while idle
//   in_valid/in_ready/in_last/in_acc   accumulator stream
//   out_valid/out_ready/out_last/out_data  packed int8 stream
//   busy                            elements in flight, partial or pending word
module conv1d_requant #(
  parameter int LANES = conv_pkg::LANES,
  parameter int ACC_W = conv_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [31:0]      cfg_mult,
  input  logic [5:0]       cfg_shift,
  input  logic [8:0]       cfg_out_offset,
  input  logic [7:0]       cfg_act_min,
  input  logic [7:0]       cfg_act_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [ACC_W-1:0] in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [31:0]      out_data,
  output logic             busy
);
  import conv_pkg::*;

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic adv;
  logic busy_int;

  // ---------------- configuration ----------------
  cfg_t cfg_reg;

  always_ff @(posedge clk) begin
    if (reset)
      cfg_reg <= CFG_DEFAULT;
    else if (cfg_we && !busy_int)
      cfg_reg <= '{mult: cfg_mult, shift: cfg_shift, out_offset: cfg_out_offset,
                   act_min: cfg_act_min, act_max: cfg_act_max};
  end

  // ---------------- S1: left shift ----------------
  logic [ACC_W-1:0] acc_shl;
  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic [31:0]      s1_x_reg;

  assign acc_shl = in_acc << left_amt(cfg_reg.shift);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_x_reg     <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s1_last_reg  <= in_last;
      s1_x_reg     <= acc_shl[31:0];
    end
  end

  // ---------------- S2/S3 ----------------
  logic       s2_valid;
  logic       s3_valid;
  logic       s3_last;
  logic [7:0] s3_byte;

  requant_mul u_requant_mul (
    .clk        (clk),
    .reset      (reset),
    .adv        (adv),
    .s1_valid   (s1_valid_reg),
    .s1_last    (s1_last_reg),
    .s1_x       (s1_x_reg),
    .mult       (cfg_reg.mult),
    .rshift     (right_amt(cfg_reg.shift)),
    .out_offset (cfg_reg.out_offset),
    .act_min    (cfg_reg.act_min),
    .act_max    (cfg_reg.act_max),
    .s2_valid   (s2_valid),
    .s3_valid   (s3_valid),
    .s3_last    (s3_last),
    .s3_byte    (s3_byte)
  );

  // ---------------- packer ----------------
  logic [31:0]       word_reg;
  logic [LANE_W-1:0] lane_reg;
  logic              out_valid_reg;
  logic              out_last_reg;

  logic [31:0]       word_base;
  logic [LANE_W-1:0] lane_base;
  logic [31:0]       word_ins;
  logic [31:0]       word_next;
  logic [LANE_W-1:0] lane_next;
  logic              out_valid_next;
  logic              out_last_next;

  // Whole pipeline freezes only while a finished word is refused downstream.
  assign adv      = !(out_valid_reg && !out_ready);
  assign in_ready = adv;

  // A word leaving this cycle frees the packer, so an arriving byte starts at lane 0.
  logic out_fire;
  assign out_fire  = out_valid_reg && out_ready;
  assign word_base = out_fire ? 32'd0 : word_reg;
  assign lane_base = out_fire ? '0 : lane_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign word_ins[31-8*gi -: 8] = (lane_base == LANE_W'(gi)) ? s3_byte
                                                               : word_base[31-8*gi -: 8];
  end
  if (LANES < 4) begin : g_pad
    assign word_ins[31-8*LANES:0] = word_base[31-8*LANES:0];
  end

  always_comb begin
    word_next      = word_base;
    lane_next      = lane_base;
    out_valid_next = out_fire ? 1'b0 : out_valid_reg;
    out_last_next  = out_fire ? 1'b0 : out_last_reg;
    if (adv && s3_valid) begin
      word_next = word_ins;
      if ((lane_base == LANE_W'(LANES - 1)) || s3_last) begin
        out_valid_next = 1'b1;
        out_last_next  = s3_last;
        lane_next      = '0;
      end else begin
        lane_next = lane_base + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg      <= '0;
      lane_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      word_reg      <= word_next;
      lane_reg      <= lane_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign busy_int  = s1_valid_reg || s2_valid || s3_valid || (lane_reg != '0) || out_valid_reg;
  assign busy      = busy_int;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_data  = word_reg;

endmodule
